// File: rtl/adc_frame_capture.sv
// I2S (24-bit, fmt=0) capture in the clk domain, one {left,right} frame per lrck period.
// Optional ADC_CAP_DROP_CNT_EN adds a saturating drop_cnt output.
module adc_frame_capture #(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bclk,
  input  logic              lrck,
  input  logic              adata,
  input  logic              enable,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic [DATA_W-1:0] left_word,
  output logic [DATA_W-1:0] right_word,
  output logic              overflow,
  output logic              frame_err,
  input  logic              clr_status
`ifdef ADC_CAP_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] FULL = CW'(DATA_W);

  typedef enum logic [1:0] {ALIGN, LEFT, RIGHT} state_t;

  state_t state, state_n;

  logic [2:0]        bclk_s;
  logic              lrck_s1, lrck_s;
  logic              adata_s1, adata_s;
  logic              lr_prev;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] left_hold;

  logic bclk_rise, boundary, full;
  logic left_latch, frame_done, err_set;
  logic load, drop;

  always_ff @(posedge clk) begin
    bclk_s   <= {bclk_s[1:0], bclk};
    lrck_s1  <= lrck;
    lrck_s   <= lrck_s1;
    adata_s1 <= adata;
    adata_s  <= adata_s1;
  end

  assign bclk_rise = bclk_s[1] & ~bclk_s[2];
  assign boundary  = bclk_rise & (lrck_s != lr_prev);
  assign full      = (bit_cnt == FULL);

  always_comb begin
    state_n    = state;
    left_latch = 1'b0;
    frame_done = 1'b0;
    err_set    = 1'b0;
    if (!enable) begin
      state_n = ALIGN;
    end else if (boundary) begin
      unique case (state)
        ALIGN: begin
          if (!lrck_s) state_n = LEFT;
        end
        LEFT: begin
          if (lrck_s) begin
            if (full) begin
              left_latch = 1'b1;
              state_n    = RIGHT;
            end else begin
              err_set = 1'b1;
              state_n = ALIGN;
            end
          end
        end
        RIGHT: begin
          if (!lrck_s) begin
            if (full) begin
              frame_done = 1'b1;
              state_n    = LEFT;
            end else begin
              err_set = 1'b1;
              state_n = ALIGN;
            end
          end
        end
        default: state_n = ALIGN;
      endcase
    end
  end

  // The boundary rise carries the previous slot's last bit, so it only clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ALIGN;
      lr_prev   <= 1'b0;
      bit_cnt   <= '0;
      shift     <= '0;
      left_hold <= '0;
    end else begin
      state <= state_n;
      if (bclk_rise) lr_prev <= lrck_s;
      if (!enable) begin
        bit_cnt <= '0;
      end else if (bclk_rise) begin
        if (boundary) begin
          bit_cnt <= '0;
        end else if (state != ALIGN && !full) begin
          shift   <= {shift[DATA_W-2:0], adata_s};
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (left_latch) left_hold <= shift;
    end
  end

  assign load = frame_done & (~sample_valid | sample_ready);
  assign drop = frame_done & sample_valid & ~sample_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_valid <= 1'b0;
      left_word    <= '0;
      right_word   <= '0;
      overflow     <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      if (load) begin
        sample_valid <= 1'b1;
        left_word    <= left_hold;
        right_word   <= shift;
      end else if (sample_ready) begin
        sample_valid <= 1'b0;
      end
      if (drop) overflow <= 1'b1;
      else if (clr_status) overflow <= 1'b0;
      if (err_set) frame_err <= 1'b1;
      else if (clr_status) frame_err <= 1'b0;
    end
  end

`ifdef ADC_CAP_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop) begin
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end else if (clr_status) begin
      drop_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_adc_frame_capture.sv
// Directed bench for adc_frame_capture: I2S stream at clk = 8x bclk,
// 64 bclk per frame, accepted frames collected into a queue.
module tb_adc_frame_capture;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bclk = 1'b0;
  logic          lrck = 1'b1;
  logic          adata = 1'b0;
  logic          enable = 1'b0;
  logic          sample_ready = 1'b0;
  logic          clr_status = 1'b0;
  logic          sample_valid;
  logic          overflow;
  logic          frame_err;
  logic [DW-1:0] left_word;
  logic [DW-1:0] right_word;
`ifdef ADC_CAP_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  int checks = 0;
  int failures = 0;
  logic [47:0] got_q[$];

  always #5 clk = ~clk;

  adc_frame_capture #(.DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bclk         (bclk),
    .lrck         (lrck),
    .adata        (adata),
    .enable       (enable),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .left_word    (left_word),
    .right_word   (right_word),
    .overflow     (overflow),
    .frame_err    (frame_err),
    .clr_status   (clr_status)
`ifdef ADC_CAP_DROP_CNT_EN
    ,
    .drop_cnt     (drop_cnt)
`endif
  );

  always @(negedge clk)
    if (!rst && sample_valid && sample_ready)
      got_q.push_back({left_word, right_word});

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_q(input string tag, input int idx,
                         input logic [23:0] l, input logic [23:0] r);
    logic [63:0] obs;
    obs = (got_q.size() > idx) ? 64'(got_q[idx]) : 64'hFFFF_FFFF_FFFF_FFFF;
    check(tag, obs, 64'({l, r}));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // bit k of a slot: k=0 is the I2S delay bit, k=1..DW carry MSB..LSB
  task automatic send_bits(input logic lr, input logic [23:0] w,
                           input int k0, input int k1);
    for (int k = k0; k < k1; k++) begin
      bclk  = 1'b0;
      lrck  = lr;
      adata = (k >= 1 && k <= DW) ? w[DW-k] : 1'b1;
      tick(4);
      bclk = 1'b1;
      tick(4);
    end
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
    send_bits(1'b0, l, 0, 32);
    send_bits(1'b1, r, 0, 32);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    got_q.delete();
  endtask

  task automatic pulse_clr;
    clr_status = 1'b1;
    tick(1);
    clr_status = 1'b0;
    tick(1);
  endtask

  initial begin
    tick(5);
    check("rst_valid", 64'(sample_valid), 64'd0);
    check("rst_left", 64'(left_word), 64'd0);
    check("rst_right", 64'(right_word), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_ferr", 64'(frame_err), 64'd0);
    enable = 1'b1;

    // basic capture, ready held high
    do_reset;
    sample_ready = 1'b1;
    send_bits(1'b1, 24'h0, 0, 32);
    repeat (3) send_frame(24'h123456, 24'hABCDEF);
    send_bits(1'b0, 24'h0, 0, 32);
    check("t1_count", 64'(got_q.size()), 64'd3);
    for (int i = 0; i < 3; i++) check_q("t1_frame", i, 24'h123456, 24'hABCDEF);
    check("t1_ferr", 64'(frame_err), 64'd0);
    check("t1_ovf", 64'(overflow), 64'd0);

    // reset mid right slot discards the partial frame
    do_reset;
    send_bits(1'b1, 24'h0, 0, 32);
    send_bits(1'b0, 24'h5A5A5A, 0, 32);
    send_bits(1'b1, 24'h3C3C3C, 0, 12);
    do_reset;
    send_bits(1'b1, 24'h3C3C3C, 12, 32);
    send_frame(24'h111111, 24'h222222);
    send_frame(24'h333333, 24'h444444);
    send_bits(1'b0, 24'h0, 0, 32);
    check("t2_count", 64'(got_q.size()), 64'd2);
    check_q("t2_first", 0, 24'h111111, 24'h222222);
    check_q("t2_second", 1, 24'h333333, 24'h444444);
    check("t2_ferr", 64'(frame_err), 64'd0);

    // backpressure: frames 2 and 3 dropped
    do_reset;
    sample_ready = 1'b0;
    send_bits(1'b1, 24'h0, 0, 32);
    send_frame(24'hC0FFEE, 24'h0BADF0);
    send_frame(24'h222222, 24'h333333);
    send_frame(24'h444444, 24'h555555);
    send_bits(1'b0, 24'h0, 0, 32);
    check("t3_valid", 64'(sample_valid), 64'd1);
    check("t3_left_hold", 64'(left_word), 64'h0C0FFEE);
    check("t3_right_hold", 64'(right_word), 64'h00BADF0);
    check("t3_ovf", 64'(overflow), 64'd1);
    check("t3_none_taken", 64'(got_q.size()), 64'd0);
`ifdef ADC_CAP_DROP_CNT_EN
    check("t3_drop_cnt", 64'(drop_cnt), 64'd2);
`endif
    pulse_clr;
    check("t3_ovf_clr", 64'(overflow), 64'd0);
`ifdef ADC_CAP_DROP_CNT_EN
    check("t3_drop_clr", 64'(drop_cnt), 64'd0);
`endif
    sample_ready = 1'b1;
    tick(2);
    check("t3_taken", 64'(got_q.size()), 64'd1);
    check_q("t3_frame", 0, 24'hC0FFEE, 24'h0BADF0);
    check("t3_valid_clr", 64'(sample_valid), 64'd0);

    // short left slot: 20 bclk
    do_reset;
    send_bits(1'b1, 24'h0, 0, 32);
    send_bits(1'b0, 24'h777777, 0, 20);
    send_bits(1'b1, 24'h888888, 0, 32);
    send_frame(24'h0F0F0F, 24'hF0F0F0);
    send_bits(1'b0, 24'h0, 0, 32);
    check("t4_ferr", 64'(frame_err), 64'd1);
    check("t4_count", 64'(got_q.size()), 64'd1);
    check_q("t4_frame", 0, 24'h0F0F0F, 24'hF0F0F0);
    pulse_clr;
    check("t4_ferr_clr", 64'(frame_err), 64'd0);

    // enable low for two frames with a pending frame
    do_reset;
    sample_ready = 1'b0;
    send_bits(1'b1, 24'h0, 0, 32);
    send_frame(24'hA1A1A1, 24'hB1B1B1);
    send_bits(1'b0, 24'hA2A2A2, 0, 2);
    enable = 1'b0;
    tick(2);
    check("t5_pend_valid", 64'(sample_valid), 64'd1);
    check("t5_pend_left", 64'(left_word), 64'hA1A1A1);
    sample_ready = 1'b1;
    tick(2);
    send_bits(1'b0, 24'hA2A2A2, 2, 32);
    send_bits(1'b1, 24'hB2B2B2, 0, 32);
    send_bits(1'b0, 24'hA3A3A3, 0, 32);
    enable = 1'b1;
    send_bits(1'b1, 24'hB3B3B3, 0, 32);
    send_frame(24'hA4A4A4, 24'hB4B4B4);
    send_bits(1'b0, 24'h0, 0, 32);
    check("t5_count", 64'(got_q.size()), 64'd2);
    check_q("t5_pending", 0, 24'hA1A1A1, 24'hB1B1B1);
    check_q("t5_resume", 1, 24'hA4A4A4, 24'hB4B4B4);
    check("t5_ovf", 64'(overflow), 64'd0);

    // negative values; ready rises on the completion cycle
    do_reset;
    sample_ready = 1'b0;
    send_bits(1'b1, 24'h0, 0, 32);
    send_frame(24'h800000, 24'hFFFFFF);
    send_frame(24'h7FFFFF, 24'h000001);
    check("t6_neg_left", 64'(left_word), 64'h800000);
    check("t6_neg_right", 64'(right_word), 64'hFFFFFF);
    bclk  = 1'b0;
    lrck  = 1'b0;
    adata = 1'b1;
    tick(4);
    bclk = 1'b1;
    tick(2);
    sample_ready = 1'b1;
    tick(1);
    check("t6_no_bubble", 64'(sample_valid), 64'd1);
    check("t6_new_left", 64'(left_word), 64'h7FFFFF);
    check("t6_new_right", 64'(right_word), 64'h000001);
    check("t6_ovf", 64'(overflow), 64'd0);
    tick(1);
    send_bits(1'b0, 24'h0, 1, 32);
    check("t6_count", 64'(got_q.size()), 64'd2);
    check_q("t6_first", 0, 24'h800000, 24'hFFFFFF);
    check_q("t6_second", 1, 24'h7FFFFF, 24'h000001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
